uart_fifo_top: RTL and testbench
================================

// Module: uart_fifo_top
// PURPOSE
//  16-entry x 8-bit synchronous FIFO for the UART 16550 TX/RX paths.
//  Provides empty/full status, overrun/underrun error pulses and a
//  programmable fill-level trigger (thre_trigger) for interrupt logic.
//  One instance per direction inside the UART core.
// PARAMETERS
//  DATA_W  8   data width in bits
//  DEPTH   16  number of entries (power of two; threshold width = log2(DEPTH))
// PORTS
//  clk           in   1   clock, all state updates on rising edge
//  rst           in   1   reset, asynchronous, active-low
//  en            in   1   enable; 0 = push/pop ignored, all state held
//  push_in       in   1   write request, din stored when en=1 and not full
//  pop_in        in   1   read request, head removed when en=1 and not empty
//  din           in   8   write data
//  dout          out  8   head-of-queue data (oldest entry)
//  empty         out  1   1 when count==0
//  full          out  1   1 when count==DEPTH
//  overrun       out  1   1-cycle pulse: push rejected because full
//  underrun      out  1   1-cycle pulse: pop rejected because empty
//  threshold     in   4   fill-level trigger point (0 = trigger disabled)
//  thre_trigger  out  1   1 when threshold!=0 and count>=threshold
// BEHAVIOUR
//  - Reset (rst=0, async): count=0, all storage cleared to 0, dout=0,
//    empty=1, full=0, overrun=0, underrun=0, thre_trigger=0. Reset
//    mid-operation discards all contents immediately.
//  - Storage: circular buffer, 4-bit rd/wr pointers wrapping 15->0,
//    5-bit count (0..16). dout = mem[rd_ptr], combinational from regs;
//    valid whenever empty=0, undefined-but-stable content otherwise.
//  - Ops per rising edge, only when en=1:
//    push & !full  -> mem[wr_ptr]<=din, wr_ptr++, count++.
//    pop & !empty  -> rd_ptr++, count--; new head on dout next cycle.
//    push & pop, 0<count<16 -> both performed, count unchanged.
//    push & pop, empty -> push only; underrun pulses.
//    push & pop, full  -> pop and push both performed (slot freed same
//      cycle), count stays 16; no overrun.
//    push & full (no pop) -> data dropped, contents unchanged, overrun=1
//      next cycle for one cycle.
//    pop & empty (no push) -> no change, underrun=1 next cycle, one cycle.
//  - overrun/underrun registered, cleared to 0 any cycle without error;
//    en=0 forces both to 0 on next edge.
//  - empty/full/thre_trigger combinational from count (and threshold);
//    update in same cycle count changes. Latency push->dout (when
//    previously empty) = 1 clock.
//  - en=0: pointers, count, memory held; requests lost, not queued.
// TESTING
//  1 Reset: rst=0 5 clocks -> empty=1 full=0 overrun=0 underrun=0
//    thre_trigger=0 dout=0.
//  2 Fill: threshold=4'ha, 20 pushes of random data, en=1 -> thre_trigger
//    rises after 10th push, full=1 after 16th, overrun pulses on
//    pushes 17..20, stored data = first 16 values.
//  3 Drain: 20 pops -> dout returns first 16 values in push order,
//    thre_trigger falls when count<10, empty=1 after 16th pop,
//    underrun pulses on pops 17..20.
//  4 Simultaneous: count=5, push+pop 8 cycles -> count stays 5, FIFO
//    order preserved across pointer wrap 15->0.
//  5 Enable gating: en=0 with push/pop toggling 10 cycles -> count,
//    dout, flags unchanged; overrun/underrun stay 0.
//  6 Async reset mid-fill: rst=0 between clocks at count=7 -> empty=1,
//    count=0 immediately, no clock needed; threshold=0 keeps
//    thre_trigger=0 at any fill level.

Source files
------------

// File: rtl/uart_fifo_top.sv
// uart_fifo_top: 16 x 8 circular-buffer FIFO for one UART 16550 direction.
// Provides empty/full status, registered overrun/underrun error pulses and a
// programmable fill-level trigger for the interrupt logic.
module uart_fifo_top #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_en,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic [DATA_W-1:0]          i_din,
  input  logic [$clog2(DEPTH)-1:0]   i_threshold,
  output logic [DATA_W-1:0]          o_dout,
  output logic                       o_empty,
  output logic                       o_full,
  output logic                       o_overrun,
  output logic                       o_underrun,
  output logic                       o_thre_trigger
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_count;
  logic              r_overrun;
  logic              r_underrun;

  logic              w_empty;
  logic              w_full;
  logic              w_do_push;
  logic              w_do_pop;
  logic              w_overrun_next;
  logic              w_underrun_next;
  logic [AW:0]       w_count_next;

  // Status flags and accepted operations, all derived from the current count.
  // A push on a full FIFO still succeeds when a pop frees the head slot in
  // the same cycle; a pop on an empty FIFO never succeeds, even with a push.
  always_comb begin
    w_empty         = (r_count == '0);
    w_full          = (r_count == CNT_FULL);
    w_do_pop        = i_en && i_pop && !w_empty;
    w_do_push       = i_en && i_push && (!w_full || w_do_pop);
    w_overrun_next  = i_en && i_push && !i_pop && w_full;
    w_underrun_next = i_en && i_pop && w_empty;
    w_count_next    = r_count;
    case ({w_do_push, w_do_pop})
      2'b10:   w_count_next = r_count + (AW+1)'(1);
      2'b01:   w_count_next = r_count - (AW+1)'(1);
      default: w_count_next = r_count;
    endcase
  end

  // Storage array: cleared on reset so dout reads 0 until the first write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_din;
    end
  end

  // Pointers and occupancy count; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= w_count_next;
    end
  end

  // Error pulses: one cycle after the rejected request, cleared otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overrun  <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_overrun  <= w_overrun_next;
      r_underrun <= w_underrun_next;
    end
  end

  // Output drive: head data straight from storage, flags from the count.
  always_comb begin
    o_dout         = r_mem[r_rd_ptr];
    o_empty        = w_empty;
    o_full         = w_full;
    o_overrun      = r_overrun;
    o_underrun     = r_underrun;
    o_thre_trigger = (i_threshold != '0) && (r_count >= {1'b0, i_threshold});
  end

endmodule

// File: tb/tb_uart_fifo_top.sv
// tb_uart_fifo_top: directed scenario with random data, checked against a
// queue-based reference model of the FIFO behaviour.
module tb_uart_fifo_top;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       i_en;
  logic       i_push;
  logic       i_pop;
  logic [7:0] i_din;
  logic [3:0] i_threshold;
  logic [7:0] o_dout;
  logic       o_empty;
  logic       o_full;
  logic       o_overrun;
  logic       o_underrun;
  logic       o_thre_trigger;

  int tests = 0;
  int fails = 0;

  // reference model state
  logic [7:0] q[$];
  logic       exp_ov;
  logic       exp_un;
  string      phase;

  uart_fifo_top #(.DATA_W(8), .DEPTH(16)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_en           (i_en),
    .i_push         (i_push),
    .i_pop          (i_pop),
    .i_din          (i_din),
    .i_threshold    (i_threshold),
    .o_dout         (o_dout),
    .o_empty        (o_empty),
    .o_full         (o_full),
    .o_overrun      (o_overrun),
    .o_underrun     (o_underrun),
    .o_thre_trigger (o_thre_trigger)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s/%s observed=%0h expected=%0h", phase, tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int n;
    n = q.size();
    chk("empty", 32'(o_empty), 32'(n == 0));
    chk("full", 32'(o_full), 32'(n == 16));
    chk("thre", 32'(o_thre_trigger), 32'((i_threshold != 0) && (n >= int'(i_threshold))));
    chk("overrun", 32'(o_overrun), 32'(exp_ov));
    chk("underrun", 32'(o_underrun), 32'(exp_un));
    if (n > 0) chk("dout", 32'(o_dout), 32'(q[0]));
  endtask

  // One clock with the given request; model updated from pre-edge occupancy.
  task automatic step(input logic en, input logic push, input logic pop, input logic [7:0] d);
    int n;
    i_en = en; i_push = push; i_pop = pop; i_din = d;
    @(posedge clk);
    n = q.size();
    if (en) begin
      exp_un = pop && (n == 0);
      exp_ov = push && !pop && (n == 16);
      if (pop && n > 0) void'(q.pop_front());
      if (push && (n < 16 || pop)) q.push_back(d);
    end else begin
      exp_ov = 1'b0;
      exp_un = 1'b0;
    end
    #1;
    check_all();
    $display("[TB] %s en=%0b push=%0b pop=%0b din=%02h -> count=%0d dout=%02h ov=%0b un=%0b thre=%0b",
             phase, en, push, pop, d, q.size(), o_dout, o_overrun, o_underrun, o_thre_trigger);
  endtask

  initial begin
    rst_n = 1'b0; i_en = 1'b0; i_push = 1'b0; i_pop = 1'b0; i_din = 8'h00; i_threshold = 4'h0;
    exp_ov = 1'b0; exp_un = 1'b0;

    // 1 reset held for 5 clocks
    phase = "reset";
    repeat (5) @(posedge clk);
    #1;
    check_all();
    chk("dout_rst", 32'(o_dout), 32'h0);
    rst_n = 1'b1;

    // 2 fill past full with trigger at 10
    phase = "fill";
    i_threshold = 4'ha;
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 1'b0, 8'($urandom_range(0, 255)));

    // 3 drain past empty
    phase = "drain";
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 1'b1, 8'h00);

    // move pointers to 10 so the simultaneous phase crosses the wrap
    phase = "advance";
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0, 8'($urandom_range(0, 255)));
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b1, 8'h00);

    // 4 simultaneous push+pop at count 5 across pointer wrap
    phase = "simul";
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 8'($urandom_range(0, 255)));
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b1, 8'($urandom_range(0, 255)));
    chk("simul_count", 32'(q.size()), 32'd5);

    // 5 enable gating with random requests
    phase = "gated";
    for (int i = 0; i < 10; i++)
      step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));

    // push+pop while full, then push+pop while empty
    phase = "edge";
    while (q.size() < 16) step(1'b1, 1'b1, 1'b0, 8'($urandom_range(0, 255)));
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, 8'($urandom_range(0, 255)));
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 1'b1, 8'h00);
    step(1'b1, 1'b1, 1'b1, 8'($urandom_range(0, 255)));
    step(1'b1, 1'b0, 1'b1, 8'h00);

    // random mixed traffic
    phase = "random";
    for (int i = 0; i < 60; i++)
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           8'($urandom_range(0, 255)));

    // 6 async reset mid-fill, then fill with trigger disabled
    phase = "async";
    while (q.size() > 0) step(1'b1, 1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 7; i++) step(1'b1, 1'b1, 1'b0, 8'($urandom_range(1, 255)));
    #1 rst_n = 1'b0;
    #1;
    q.delete(); exp_ov = 1'b0; exp_un = 1'b0;
    check_all();
    chk("dout_async", 32'(o_dout), 32'h0);
    #1 rst_n = 1'b1;
    phase = "thr0";
    i_threshold = 4'h0;
    for (int i = 0; i < 17; i++) step(1'b1, 1'b1, 1'b0, 8'($urandom_range(0, 255)));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
